// File: rtl/lookup_ctrl_writer.sv
// ---------------------------------------------------------------------------
// lookup_ctrl_writer
//
// Control-plane producer for one pipeline stage's match tables. It takes
// 256-bit configuration packets from the control stream and keeps only those
// addressed to this stage. From each accepted packet it builds either a
// key/mask CAM entry or an action RAM entry, then issues a one-cycle write
// strobe on the lookup engine's control channel.
//
// Packet layout:
//   header beat  [255:248] stage, [247:240] type (0x01 key, 0x02 action),
//                [239:236] entry address
//   key packet   : header, key beat, mask beat
//   action packet: header, bits[255:0], bits[511:256], bits[624:512]
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tlast/tready   control stream (this block is sink)
//   lookup_din, lookup_din_mask, lookup_din_addr, lookup_din_en
//                        CAM write channel (strobe is one cycle wide)
//   action_data_in, action_addr, action_en
//                        action RAM write channel (strobe is one cycle wide)
//   err_cnt              (only with LKUP_WR_ERR_CNT_EN) count of aborted
//                        packets and unknown-type headers for this stage,
//                        saturating at 0xFFFF
//
// Optional feature macro: LKUP_WR_ERR_CNT_EN
// ---------------------------------------------------------------------------
module lookup_ctrl_writer #(
   parameter int unsigned STAGE    = 0,
   parameter int unsigned KEY_LEN  = 197,
   parameter int unsigned ACT_LEN  = 25,
   parameter int unsigned C_DATA_W = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [C_DATA_W-1:0]     s_axis_tdata,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tlast,
   output logic                    s_axis_tready,
   output logic [KEY_LEN-1:0]      lookup_din,
   output logic [KEY_LEN-1:0]      lookup_din_mask,
   output logic [3:0]              lookup_din_addr,
   output logic                    lookup_din_en,
   output logic [ACT_LEN*25-1:0]   action_data_in,
   output logic [3:0]              action_addr,
   output logic                    action_en
`ifdef LKUP_WR_ERR_CNT_EN
   ,
   output logic [15:0]             err_cnt
`endif
);

   localparam int unsigned ACT_W  = ACT_LEN * 25;
   // Width of the last action beat's payload (625 - 512 = 113 by default).
   localparam int unsigned ACT3_W = ACT_W - 2 * C_DATA_W;

   localparam logic [7:0] STAGE_ID  = 8'(STAGE);
   localparam logic [7:0] TYPE_KEY  = 8'h01;
   localparam logic [7:0] TYPE_ACT  = 8'h02;

   typedef enum logic [3:0] {
      S_HDR,
      S_KEY,
      S_MASK,
      S_ACT1,
      S_ACT2,
      S_ACT3,
      S_WRK,
      S_WRA,
      S_DROP
   } state_t;

   state_t r_state;
   state_t w_next;

   logic                w_accept;
   logic                w_stage_hit;
   logic [7:0]          w_type;

   // Shadow registers for the entry under assembly.
   logic [3:0]          r_addr;
   logic [KEY_LEN-1:0]  r_key;
   logic [C_DATA_W-1:0] r_act_lo;
   logic [C_DATA_W-1:0] r_act_mid;
   // Remembers whether the final data beat closed the packet, so the write
   // state knows whether trailing beats must be drained.
   logic                r_last;

   assign w_accept    = s_axis_tvalid & s_axis_tready;
   assign w_stage_hit = (s_axis_tdata[255:248] == STAGE_ID);
   assign w_type      = s_axis_tdata[247:240];

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_HDR;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------- next state / outputs
   always_comb begin
      w_next        = r_state;
      s_axis_tready = 1'b1;
      lookup_din_en = 1'b0;
      action_en     = 1'b0;

      case (r_state)
         S_HDR: begin
            if (w_accept) begin
               // A header that is also the last beat carries no entry.
               if (s_axis_tlast) begin
                  w_next = S_HDR;
               end else if (w_stage_hit && (w_type == TYPE_KEY)) begin
                  w_next = S_KEY;
               end else if (w_stage_hit && (w_type == TYPE_ACT)) begin
                  w_next = S_ACT1;
               end else begin
                  w_next = S_DROP;
               end
            end
         end
         S_KEY: begin
            if (w_accept) begin
               w_next = s_axis_tlast ? S_HDR : S_MASK;
            end
         end
         S_MASK: begin
            if (w_accept) begin
               w_next = S_WRK;
            end
         end
         S_ACT1: begin
            if (w_accept) begin
               w_next = s_axis_tlast ? S_HDR : S_ACT2;
            end
         end
         S_ACT2: begin
            if (w_accept) begin
               w_next = s_axis_tlast ? S_HDR : S_ACT3;
            end
         end
         S_ACT3: begin
            if (w_accept) begin
               w_next = S_WRA;
            end
         end
         S_WRK: begin
            s_axis_tready = 1'b0;
            lookup_din_en = 1'b1;
            w_next        = r_last ? S_HDR : S_DROP;
         end
         S_WRA: begin
            s_axis_tready = 1'b0;
            action_en     = 1'b1;
            w_next        = r_last ? S_HDR : S_DROP;
         end
         S_DROP: begin
            if (w_accept && s_axis_tlast) begin
               w_next = S_HDR;
            end
         end
         default: begin
            w_next = S_HDR;
         end
      endcase
   end

   // ------------------------------------------------------ entry assembly
   // An early tlast leaves the shadows untouched so a partial packet never
   // disturbs previously collected data.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         case (r_state)
            S_HDR:  r_addr <= s_axis_tdata[239:236];
            S_KEY:  if (!s_axis_tlast) r_key <= s_axis_tdata[KEY_LEN-1:0];
            S_ACT1: if (!s_axis_tlast) r_act_lo <= s_axis_tdata;
            S_ACT2: if (!s_axis_tlast) r_act_mid <= s_axis_tdata;
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------- write outputs
   // Output data/address load on the final data beat, so they change in
   // exactly the cycle the strobe is high and hold until the next write.
   always_ff @(posedge clk) begin
      if (rst) begin
         lookup_din      <= '0;
         lookup_din_mask <= '0;
         lookup_din_addr <= '0;
         action_data_in  <= '0;
         action_addr     <= '0;
         r_last          <= 1'b0;
      end else if (w_accept) begin
         if (r_state == S_MASK) begin
            lookup_din      <= r_key;
            lookup_din_mask <= s_axis_tdata[KEY_LEN-1:0];
            lookup_din_addr <= r_addr;
            r_last          <= s_axis_tlast;
         end else if (r_state == S_ACT3) begin
            action_data_in  <= {s_axis_tdata[ACT3_W-1:0], r_act_mid, r_act_lo};
            action_addr     <= r_addr;
            r_last          <= s_axis_tlast;
         end
      end
   end

`ifdef LKUP_WR_ERR_CNT_EN
   // ------------------------------------------------------- error counter
   logic w_abort;
   logic w_bad_type;
   logic w_err_evt;

   assign w_abort    = w_accept && s_axis_tlast &&
                       ((r_state == S_KEY) || (r_state == S_ACT1) ||
                        (r_state == S_ACT2));
   // Foreign-stage packets are not this stage's errors, so only headers
   // addressed here with an unrecognised type are counted.
   assign w_bad_type = w_accept && (r_state == S_HDR) && w_stage_hit &&
                       (w_type != TYPE_KEY) && (w_type != TYPE_ACT);
   assign w_err_evt  = w_abort || w_bad_type;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (w_err_evt && (err_cnt != 16'hFFFF)) begin
         err_cnt <= err_cnt + 16'd1;
      end
   end
`else
   // Error counting is not built in this configuration.
`endif

endmodule

// File: tb/tb_lookup_ctrl_writer.sv
module tb_lookup_ctrl_writer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [255:0] s_axis_tdata = '0;
   logic         s_axis_tvalid = 1'b0;
   logic         s_axis_tlast = 1'b0;
   logic         s_axis_tready;
   logic [196:0] lookup_din;
   logic [196:0] lookup_din_mask;
   logic [3:0]   lookup_din_addr;
   logic         lookup_din_en;
   logic [624:0] action_data_in;
   logic [3:0]   action_addr;
   logic         action_en;
`ifdef LKUP_WR_ERR_CNT_EN
   logic [15:0]  err_cnt;
`endif

   int total = 0;
   int bad   = 0;
   int n_key = 0;
   int n_act = 0;

   lookup_ctrl_writer #(
      .STAGE(0), .KEY_LEN(197), .ACT_LEN(25), .C_DATA_W(256)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .s_axis_tdata   (s_axis_tdata),
      .s_axis_tvalid  (s_axis_tvalid),
      .s_axis_tlast   (s_axis_tlast),
      .s_axis_tready  (s_axis_tready),
      .lookup_din     (lookup_din),
      .lookup_din_mask(lookup_din_mask),
      .lookup_din_addr(lookup_din_addr),
      .lookup_din_en  (lookup_din_en),
      .action_data_in (action_data_in),
      .action_addr    (action_addr),
      .action_en      (action_en)
`ifdef LKUP_WR_ERR_CNT_EN
      ,
      .err_cnt        (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Strobe counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (lookup_din_en) n_key++;
      if (action_en)     n_act++;
   end

   task automatic chk(input string tag, input logic [624:0] obs, input logic [624:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One beat, presented while tready is expected high; accepted on the edge.
   task automatic beat(input string tag, input logic [255:0] d, input logic l);
      chk({tag, "_rdy"}, 625'(s_axis_tready), 625'(1));
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = l;
      tick();
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tdata  = '0;
   endtask

   function automatic logic [255:0] hdr(input logic [7:0] st, input logic [7:0] ty,
                                        input logic [3:0] ad);
      return {st, ty, ad, 236'd0};
   endfunction

   logic [255:0] cA, cB, cC, k2, m2, k3, m3;
   logic [624:0] e_act, e_k2;

   initial begin
      cA = {8{32'hA0A0_0001}};
      cB = {8{32'hB0B0_0002}};
      cC = {8{32'hC0C0_0003}};
      e_act = {cC[112:0], cB, cA};
      k2 = '1;
      m2 = {8{32'h0F0F_1234}};
      e_k2 = '0;
      e_k2[196:0] = '1;
      k3 = 256'h55AA;
      m3 = 256'hFF00;

      // Reset state
      tick();
      tick();
      chk("rst_rdy",   625'(s_axis_tready),   625'(1));
      chk("rst_ken",   625'(lookup_din_en),   625'(0));
      chk("rst_aen",   625'(action_en),       625'(0));
      chk("rst_din",   625'(lookup_din),      625'(0));
      chk("rst_adata", action_data_in,        625'(0));
      rst = 1'b0;

      // Key entry
      beat("k1_hdr",  hdr(8'h00, 8'h01, 4'h5), 1'b0);
      beat("k1_key",  256'h1_DEAD_BEEF, 1'b0);
      beat("k1_mask", 256'h0, 1'b1);
      chk("k1_en",    625'(lookup_din_en),   625'(1));
      chk("k1_din",   625'(lookup_din),      625'h1DEADBEEF);
      chk("k1_mask",  625'(lookup_din_mask), 625'(0));
      chk("k1_addr",  625'(lookup_din_addr), 625'(5));
      chk("k1_aen",   625'(action_en),       625'(0));
      chk("k1_rdy0",  625'(s_axis_tready),   625'(0));
      tick();
      chk("k1_en_off", 625'(lookup_din_en),  625'(0));
      chk("k1_rdy1",   625'(s_axis_tready),  625'(1));
      chk("k1_hold",   625'(lookup_din),     625'h1DEADBEEF);
      chk("k1_count",  625'(n_key),          625'(1));

      // Action entry
      beat("a1_hdr", hdr(8'h00, 8'h02, 4'hA), 1'b0);
      beat("a1_A", cA, 1'b0);
      beat("a1_B", cB, 1'b0);
      beat("a1_C", cC, 1'b1);
      chk("a1_en",   625'(action_en),      625'(1));
      chk("a1_data", action_data_in,       e_act);
      chk("a1_addr", 625'(action_addr),    625'hA);
      chk("a1_ken",  625'(lookup_din_en),  625'(0));
      chk("a1_rdy0", 625'(s_axis_tready),  625'(0));
      chk("a1_khold", 625'(lookup_din),    625'h1DEADBEEF);
      tick();
      chk("a1_en_off", 625'(action_en),    625'(0));
      chk("a1_rdy1",   625'(s_axis_tready), 625'(1));
      chk("a1_count",  625'(n_act),        625'(1));

      // Stage mismatch: header + 4 beats, all accepted, nothing written
      beat("sm_hdr", hdr(8'h03, 8'h01, 4'h7), 1'b0);
      beat("sm_b1", 256'h1, 1'b0);
      beat("sm_b2", 256'h2, 1'b0);
      beat("sm_b3", 256'h3, 1'b0);
      beat("sm_b4", 256'h4, 1'b1);
      chk("sm_nkey", 625'(n_key), 625'(1));
      chk("sm_nact", 625'(n_act), 625'(1));
`ifdef LKUP_WR_ERR_CNT_EN
      chk("sm_err", 625'(err_cnt), 625'(0));
`endif

      // Early tlast on ACT1: abort, no strobe, outputs hold
      beat("et_hdr", hdr(8'h00, 8'h02, 4'h4), 1'b0);
      beat("et_b1", 256'hFACE, 1'b1);
      chk("et_aen",   625'(action_en),   625'(0));
      chk("et_hold",  action_data_in,    e_act);
      chk("et_addr",  625'(action_addr), 625'hA);
      chk("et_nact",  625'(n_act),       625'(1));
`ifdef LKUP_WR_ERR_CNT_EN
      chk("et_err", 625'(err_cnt), 625'(1));
      // Unknown type for this stage counts too
      beat("ut_hdr", hdr(8'h00, 8'h07, 4'h1), 1'b1);
      chk("ut_err", 625'(err_cnt), 625'(2));
`endif

      // Overlong key packet (5 beats): write after beat 3, rest drained
      beat("ol_hdr",  hdr(8'h00, 8'h01, 4'h9), 1'b0);
      beat("ol_key",  k2, 1'b0);
      beat("ol_mask", m2, 1'b0);
      chk("ol_en",   625'(lookup_din_en),   625'(1));
      chk("ol_din",  625'(lookup_din),      e_k2);
      chk("ol_mask", 625'(lookup_din_mask), 625'(m2[196:0]));
      chk("ol_addr", 625'(lookup_din_addr), 625'(9));
      tick();
      beat("ol_b4", hdr(8'h00, 8'h01, 4'hF), 1'b0);
      beat("ol_b5", 256'h1234, 1'b1);
      chk("ol_nkey", 625'(n_key), 625'(2));
      chk("ol_din_hold", 625'(lookup_din), e_k2);

      // Following key packet
      beat("k3_hdr",  hdr(8'h00, 8'h01, 4'h3), 1'b0);
      beat("k3_key",  k3, 1'b0);
      beat("k3_mask", m3, 1'b1);
      chk("k3_en",   625'(lookup_din_en),   625'(1));
      chk("k3_din",  625'(lookup_din),      625'h55AA);
      chk("k3_mask", 625'(lookup_din_mask), 625'hFF00);
      chk("k3_addr", 625'(lookup_din_addr), 625'(3));
      tick();

      // Reset after the key beat: no strobe, outputs cleared
      beat("rm_hdr", hdr(8'h00, 8'h01, 4'h6), 1'b0);
      beat("rm_key", 256'hBEEF, 1'b0);
      rst = 1'b1;
      tick();
      chk("rm_rdy",   625'(s_axis_tready),   625'(1));
      chk("rm_ken",   625'(lookup_din_en),   625'(0));
      chk("rm_din",   625'(lookup_din),      625'(0));
      chk("rm_mask",  625'(lookup_din_mask), 625'(0));
      chk("rm_addr",  625'(lookup_din_addr), 625'(0));
      chk("rm_adata", action_data_in,        625'(0));
      chk("rm_nkey",  625'(n_key),           625'(3));
`ifdef LKUP_WR_ERR_CNT_EN
      chk("rm_err", 625'(err_cnt), 625'(0));
`endif
      rst = 1'b0;
      beat("k4_hdr",  hdr(8'h00, 8'h01, 4'hC), 1'b0);
      beat("k4_key",  256'h0ABC_DEF0, 1'b0);
      beat("k4_mask", 256'h0000_FFFF, 1'b1);
      chk("k4_en",   625'(lookup_din_en),   625'(1));
      chk("k4_din",  625'(lookup_din),      625'h0ABCDEF0);
      chk("k4_mask", 625'(lookup_din_mask), 625'hFFFF);
      chk("k4_addr", 625'(lookup_din_addr), 625'hC);
      tick();
      chk("k4_nkey", 625'(n_key), 625'(4));
      chk("k4_nact", 625'(n_act), 625'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
